// File: rtl/lsu_mem_port_if.sv
// Word-oriented data-memory bus between the load/store port and the memory.
// The master drives the request side; the slave returns ready, rvalid and rdata.
interface lsu_mem_port_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store port: turns memory-stage requests into word-aligned bus transfers
// and stalls the single-cycle core until the transfer completes or faults.
//
// state  | meaning
// IDLE   | waiting for mem_read/mem_write; fault checks and request setup
// REQ    | m.req held until the bus accepts it
// WAIT_R | load accepted, waiting for read data
// DONE   | completion cycle: ld_valid/err pulse, core released
module lsu_mem_port #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] ld_raw,
  output logic [2:0]  ld_ex,
  output logic        ld_valid,
  output logic        err,
  lsu_mem_port_if.master m
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [1:0]    state;
  logic          req_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic [TW-1:0] cnt;

  logic          is_store;
  logic          f3_ok;
  logic          misal;
  logic          fault;
  logic          to_hit;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;

  always_comb begin
    is_store = mem_write & ~mem_read;
    if (mem_read)
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
    misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
            ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    fault = ~f3_ok | misal;
    case (funct3[1:0])
      2'b00: begin
        be_n = 4'b0001 << addr[1:0];
        wd_n = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_n = 4'b0011 << {addr[1], 1'b0};
        wd_n = {2{wdata[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = wdata;
      end
    endcase
  end

  // A handshake arriving in the last allowed cycle is checked before this.
  assign to_hit = (TIMEOUT != 0) && (cnt == T_LAST);

  assign stall = ((state == IDLE) && (mem_read || mem_write)) ||
                 (state == REQ) || (state == WAIT_R);

  assign m.req   = req_q;
  assign m.we    = we_q;
  assign m.addr  = addr_q;
  assign m.be    = be_q;
  assign m.wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      cnt      <= '0;
      ld_raw   <= '0;
      ld_ex    <= '0;
      ld_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      ld_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            if (fault) begin
              err    <= 1'b1;
              ld_raw <= '0;
              state  <= DONE;
            end else begin
              req_q   <= 1'b1;
              we_q    <= is_store;
              addr_q  <= {addr[31:2], 2'b00};
              be_q    <= be_n;
              wdata_q <= wd_n;
              off_q   <= addr[1:0];
              f3_q    <= funct3;
              cnt     <= '0;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (m.ready) begin
            req_q <= 1'b0;
            state <= we_q ? DONE : WAIT_R;
          end else if (to_hit) begin
            req_q  <= 1'b0;
            err    <= 1'b1;
            ld_raw <= '0;
            state  <= DONE;
          end
        end
        WAIT_R: begin
          cnt <= cnt + 1'b1;
          if (m.rvalid) begin
            ld_raw   <= m.rdata >> {off_q, 3'b000};
            ld_ex    <= f3_q;
            ld_valid <= 1'b1;
            state    <= DONE;
          end else if (to_hit) begin
            err    <= 1'b1;
            ld_raw <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          be_q  <= '0;
          we_q  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: stimulus queues expected bus requests and
// load completions, independent monitors pop and compare them.
module tb_lsu_mem_port;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] ld_raw;
  logic [2:0]  ld_ex;
  logic        ld_valid;
  logic        err;

  lsu_mem_port_if bus();

  lsu_mem_port #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .ld_raw   (ld_raw),
    .ld_ex    (ld_ex),
    .ld_valid (ld_valid),
    .err      (err),
    .m        (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic        err;
    logic        vld;
    logic [31:0] raw;
    logic [2:0]  ex;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  bus_t bus_exp;
  rsp_t rsp_exp;
  int   errors = 0;
  int   checks = 0;
  logic in_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
    bus_q.push_back({we, a, be, wd});
  endtask

  task automatic push_rsp(input logic e, input logic v, input logic [31:0] raw,
                          input logic [2:0] ex);
    rsp_q.push_back({e, v, raw, ex});
  endtask

  // Bus acceptance and completion monitor, sampled mid low-phase.
  always begin
    @(negedge clk);
    #3;
    if (bus.req && bus.ready) begin
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected: got addr %h be %b expected no request", bus.addr, bus.be);
      end else begin
        bus_exp = bus_q.pop_front();
        chk("m_we", {31'b0, bus.we}, {31'b0, bus_exp.we});
        chk("m_addr", bus.addr, bus_exp.addr);
        chk("m_be", {28'b0, bus.be}, {28'b0, bus_exp.be});
        if (bus_exp.we) chk("m_wdata", bus.wdata, bus_exp.wdata);
      end
    end
    if (ld_valid || err) begin
      if (rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got ld_valid %b err %b expected no pulse", ld_valid, err);
      end else begin
        rsp_exp = rsp_q.pop_front();
        chk("err", {31'b0, err}, {31'b0, rsp_exp.err});
        chk("ld_valid", {31'b0, ld_valid}, {31'b0, rsp_exp.vld});
        chk("ld_raw", ld_raw, rsp_exp.raw);
        if (rsp_exp.vld) chk("ld_ex", {29'b0, ld_ex}, {29'b0, rsp_exp.ex});
      end
    end
  end

  // One core access with a scripted bus slave; rdy_dly/rv_dly < 0 mean never.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int rdy_dly, input int rv_dly, input logic [31:0] rdat,
                        input int exp_stall, input int exp_req, input string name);
    int   stc = 0;
    int   reqc = 0;
    int   wc = 0;
    logic acc_ld = 1'b0;
    logic done = 1'b0;
    logic unstable = 1'b0;
    bus_t first = '0;
    if (in_done) begin
      @(negedge clk);
      #1;
    end
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    for (int i = 0; i < 30 && !done; i++) begin
      if (!stall) begin
        done = 1'b1;
        chk({name, "_req_in_done"}, {31'b0, bus.req}, 32'h0);
      end else begin
        stc++;
        if (bus.req) begin
          reqc++;
          if (reqc == 1) first = {bus.we, bus.addr, bus.be, bus.wdata};
          else if (first != {bus.we, bus.addr, bus.be, bus.wdata}) unstable = 1'b1;
          bus.ready = (rdy_dly >= 0) && (reqc > rdy_dly);
          if (bus.ready && !bus.we) acc_ld = 1'b1;
        end else begin
          bus.ready = 1'b0;
          if (acc_ld) begin
            wc++;
            bus.rvalid = (rv_dly >= 0) && (wc > rv_dly);
            bus.rdata  = bus.rvalid ? rdat : 32'h0;
          end
        end
        @(negedge clk);
        #2;
      end
    end
    bus.ready = 1'b0; bus.rvalid = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    in_done = 1'b1;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_complete: got stall stuck high expected release within 30 cycles", name);
    end else begin
      chk({name, "_stall_cycles"}, stc, exp_stall);
      chk({name, "_req_cycles"}, reqc, exp_req);
      if (reqc > 0) chk({name, "_req_stable"}, {31'b0, unstable}, 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0;
    bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    #12;
    chk("rst_m_req", {31'b0, bus.req}, 32'h0);
    chk("rst_m_addr", bus.addr, 32'h0);
    chk("rst_m_be", {28'b0, bus.be}, 32'h0);
    chk("rst_outs", {ld_raw[30:0], ld_valid}, 32'h0);
    chk("rst_stall_idle", {31'b0, stall}, 32'h0);
    mem_read = 1'b1;
    #1;
    chk("rst_stall_req", {31'b0, stall}, 32'h1);
    mem_read = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;

    push_bus(1'b0, 32'h1000, 4'b1000, 32'h0);
    push_rsp(1'b0, 1'b1, 32'h000000A1, 3'b100);
    access(1, 0, 3'b100, 32'h1003, 32'h0, 0, 0, 32'hA1B2C3D4, 3, 1, "lbu");

    push_bus(1'b1, 32'h2000, 4'b1100, 32'hBEEFBEEF);
    access(0, 1, 3'b001, 32'h2002, 32'h0000BEEF, 3, -1, 32'h0, 5, 4, "sh");

    push_bus(1'b0, 32'h3000, 4'b1100, 32'h0);
    push_rsp(1'b0, 1'b1, 32'h0000CAFE, 3'b001);
    access(1, 0, 3'b001, 32'h3002, 32'h0, 1, 1, 32'hCAFEF00D, 5, 2, "lh");

    push_bus(1'b1, 32'h3000, 4'b0010, 32'hABABABAB);
    access(0, 1, 3'b000, 32'h3001, 32'h000000AB, 0, -1, 32'h0, 2, 1, "sb");

    push_bus(1'b0, 32'h3000, 4'b0001, 32'h0);
    push_rsp(1'b0, 1'b1, 32'h11223344, 3'b100);
    access(1, 1, 3'b100, 32'h3000, 32'h0, 0, 0, 32'h11223344, 3, 1, "rd_wins");

    push_rsp(1'b1, 1'b0, 32'h0, 3'b000);
    access(1, 0, 3'b010, 32'h3001, 32'h0, 0, 0, 32'h0, 1, 0, "lw_mis");
    push_rsp(1'b1, 1'b0, 32'h0, 3'b000);
    access(1, 0, 3'b001, 32'h3003, 32'h0, 0, 0, 32'h0, 1, 0, "lh_mis");
    push_rsp(1'b1, 1'b0, 32'h0, 3'b000);
    access(1, 0, 3'b011, 32'h3000, 32'h0, 0, 0, 32'h0, 1, 0, "ld_f3_011");
    push_rsp(1'b1, 1'b0, 32'h0, 3'b000);
    access(0, 1, 3'b100, 32'h3000, 32'h0, 0, 0, 32'h0, 1, 0, "st_f3_100");

    push_rsp(1'b1, 1'b0, 32'h0, 3'b000);
    access(1, 0, 3'b010, 32'h4000, 32'h0, -1, -1, 32'h0, 5, 4, "to_req");
    push_bus(1'b0, 32'h4008, 4'b1111, 32'h0);
    push_rsp(1'b1, 1'b0, 32'h0, 3'b000);
    access(1, 0, 3'b010, 32'h4008, 32'h0, 0, -1, 32'h0, 5, 1, "to_wait");
    push_bus(1'b0, 32'h4000, 4'b1111, 32'h0);
    push_rsp(1'b0, 1'b1, 32'h12345678, 3'b010);
    access(1, 0, 3'b010, 32'h4000, 32'h0, 3, 0, 32'h12345678, 6, 4, "rdy_last");

    // Reset while a load sits in WAIT_R.
    @(negedge clk); #1;
    push_bus(1'b0, 32'h4010, 4'b1111, 32'h0);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h4010;
    @(negedge clk); #1;
    bus.ready = 1'b1;
    @(negedge clk); #1;
    bus.ready = 1'b0;
    chk("wr_stall", {31'b0, stall}, 32'h1);
    chk("wr_req", {31'b0, bus.req}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_addr", bus.addr, 32'h0);
    chk("mid_rst_m_be", {28'b0, bus.be}, 32'h0);
    chk("mid_rst_ld_raw", ld_raw, 32'h0);
    chk("mid_rst_ld_ex", {29'b0, ld_ex}, 32'h0);
    chk("mid_rst_stall", {31'b0, stall}, 32'h1);
    mem_read = 1'b0;
    #1;
    chk("mid_rst_stall_idle", {31'b0, stall}, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    in_done = 1'b0;
    @(negedge clk); #1;
    bus.rvalid = 1'b1; bus.rdata = 32'hDEADBEEF;
    @(negedge clk); #1;
    bus.rvalid = 1'b0;
    @(negedge clk); #1;
    chk("late_rvalid_raw", ld_raw, 32'h0);
    chk("late_rvalid_stall", {31'b0, stall}, 32'h0);

    push_bus(1'b0, 32'h5000, 4'b0001, 32'h0);
    push_rsp(1'b0, 1'b1, 32'h998877F0, 3'b000);
    access(1, 0, 3'b000, 32'h5000, 32'h0, 0, 0, 32'h998877F0, 3, 1, "lb_after_rst");

    push_bus(1'b0, 32'h6000, 4'b1111, 32'h0);
    push_rsp(1'b0, 1'b1, 32'h01020304, 3'b010);
    access(1, 0, 3'b010, 32'h6000, 32'h0, 0, 0, 32'h01020304, 3, 1, "lw_b2b");
    push_bus(1'b1, 32'h6004, 4'b1111, 32'h55667788);
    access(0, 1, 3'b010, 32'h6004, 32'h55667788, 0, -1, 32'h0, 2, 1, "sw_b2b");

    repeat (3) @(negedge clk);
    #1;
    chk("bus_q_drained", bus_q.size(), 32'h0);
    chk("rsp_q_drained", rsp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
